// File: rtl/dwt_row_sequencer_pkg.sv
// Shared types and defaults for the lifting-wavelet row sequencer.
// Contents: FSM state enum, default image/datapath geometry, pair-index width helper.
// No ports; imported by the sequencer, its valid pipe and its bus interface.
package dwt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_EVEN,
    FETCH_ODD,
    DRAIN,
    DONE
  } state_t;

  localparam int DWT_IMG_W  = 8;
  localparam int DWT_IMG_H  = 8;
  localparam int DWT_DATA_W = 8;
  localparam int DWT_LAT    = 3;
  localparam int DWT_ADDR_W = 6;

  // Bits needed to hold a pair index 0 .. (w*h/2 - 1).
  function automatic int pair_idx_w(input int img_w, input int img_h);
    int n_pairs;
    n_pairs = img_w * img_h / 2;
    if (n_pairs <= 1) return 1;
    return $clog2(n_pairs);
  endfunction

endpackage

// File: rtl/dwt_row_sequencer_if.sv
// Bus bundle between the sequencer, the pixel ROM, the lifting datapath and the coefficient RAM.
// Ports (signals): rd_addr/rd_en/rd_data (ROM), even_o/odd_o/pair_valid (datapath),
// wr_addr_l/wr_addr_h/wr_en (coefficient RAM). master = sequencer side, slave = environment side.
interface dwt_row_sequencer_if
  import dwt_pkg::*;
#(
  parameter int ADDR_W = DWT_ADDR_W,
  parameter int DATA_W = DWT_DATA_W
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] even_o;
  logic [DATA_W-1:0] odd_o;
  logic              pair_valid;
  logic [ADDR_W-1:0] wr_addr_l;
  logic [ADDR_W-1:0] wr_addr_h;
  logic              wr_en;

  modport master (
    output rd_addr, rd_en, even_o, odd_o, pair_valid, wr_addr_l, wr_addr_h, wr_en,
    input  rd_data
  );

  modport slave (
    input  rd_addr, rd_en, even_o, odd_o, pair_valid, wr_addr_l, wr_addr_h, wr_en,
    output rd_data
  );
endinterface

// File: rtl/dwt_row_sequencer_valid_pipe.sv
// LAT-deep shift register tracking issued pairs; turns each into a coefficient write LAT cycles later.
// Ports: i_clr (restart address counters), i_vld (pair issued), o_wr_en/o_wr_addr_l/o_wr_addr_h,
// o_empty (nothing in flight once the current cycle's write completes).
module dwt_valid_pipe
  import dwt_pkg::*;
#(
  parameter int IMG_W  = DWT_IMG_W,
  parameter int LAT    = DWT_LAT,
  parameter int ADDR_W = DWT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_vld,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr_l,
  output logic [ADDR_W-1:0] o_wr_addr_h,
  output logic              o_empty
);
  localparam logic [ADDR_W-1:0] HALF     = ADDR_W'(IMG_W / 2);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W / 2 - 1);

  logic [LAT-1:0]    r_vld;
  logic [ADDR_W-1:0] r_base [LAT];
  logic [ADDR_W-1:0] r_col  [LAT];
  // Address of the next pair to enter the pipe: row base plus column, no divider.
  logic [ADDR_W-1:0] r_cnt_base;
  logic [ADDR_W-1:0] r_cnt_col;
  logic              w_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld      <= '0;
      r_cnt_base <= '0;
      r_cnt_col  <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_base[i] <= '0;
        r_col[i]  <= '0;
      end
    end else begin
      r_vld[0]  <= i_vld;
      r_base[0] <= r_cnt_base;
      r_col[0]  <= r_cnt_col;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_base[i] <= r_base[i-1];
        r_col[i]  <= r_col[i-1];
      end
      if (i_clr) begin
        r_cnt_base <= '0;
        r_cnt_col  <= '0;
      end else if (i_vld) begin
        // Row wrap happens in the same cycle as the last column; no bubble.
        if (r_cnt_col == COL_LAST) begin
          r_cnt_col  <= '0;
          r_cnt_base <= r_cnt_base + ADDR_W'(IMG_W);
        end else begin
          r_cnt_col <= r_cnt_col + 1'b1;
        end
      end
    end
  end

  // The output stage is excluded: a pair writing this cycle is finished after the edge.
  always_comb begin
    w_pending = i_vld;
    for (int i = 0; i < LAT - 1; i++) w_pending = w_pending | r_vld[i];
  end

  assign o_empty     = !w_pending;
  assign o_wr_en     = r_vld[LAT-1];
  assign o_wr_addr_l = o_wr_en ? (r_base[LAT-1] + r_col[LAT-1]) : '0;
  assign o_wr_addr_h = o_wr_en ? (r_base[LAT-1] + HALF + r_col[LAT-1]) : '0;

endmodule

// File: rtl/dwt_row_sequencer.sv
// Walks a full image in the pixel ROM as even/odd pairs, feeds the lifting datapath one pair per
// 2 cycles and generates coefficient writes (L to left half of the row, H to right half).
// Ports: clk, rst_n, start, hold, bus (master modport), busy, done.
// Optional build macro DWT_SEQ_HOLD_EN: hold freezes fetching; otherwise hold is ignored.
module dwt_row_sequencer
  import dwt_pkg::*;
#(
  parameter int IMG_W  = DWT_IMG_W,
  parameter int IMG_H  = DWT_IMG_H,
  parameter int DATA_W = DWT_DATA_W,
  parameter int LAT    = DWT_LAT,
  parameter int ADDR_W = DWT_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 hold,
  dwt_row_sequencer_if.master  bus,
  output logic                 busy,
  output logic                 done
);
  localparam int N_PAIRS = IMG_W * IMG_H / 2;
  localparam int PW      = pair_idx_w(IMG_W, IMG_H);
  localparam logic [PW-1:0] LAST_N = PW'(N_PAIRS - 1);

  state_t            r_state;
  logic [PW-1:0]     r_n;
  logic [DATA_W-1:0] r_even;
  logic [DATA_W-1:0] r_odd;
  logic              r_pair_vld;
  logic              r_busy;
  logic              r_done;
  logic              w_hold;
  logic              w_fetch;
  logic              w_empty;

`ifdef DWT_SEQ_HOLD_EN
  assign w_hold = hold;
`else
  logic w_unused_hold;
  assign w_unused_hold = hold;
  assign w_hold        = 1'b0;
`endif

  assign w_fetch = (r_state == FETCH_EVEN) || (r_state == FETCH_ODD);

  // Only the fetch states stall on hold; the drain keeps writing regardless.
  assign bus.rd_en   = w_fetch && !w_hold;
  assign bus.rd_addr = w_fetch ? ADDR_W'({r_n, (r_state == FETCH_ODD)}) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_n        <= '0;
      r_even     <= '0;
      r_odd      <= '0;
      r_pair_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_pair_vld <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= FETCH_EVEN;
          r_n     <= '0;
          r_busy  <= 1'b1;
        end
        FETCH_EVEN: if (!w_hold) begin
          r_even  <= bus.rd_data;
          r_state <= FETCH_ODD;
        end
        FETCH_ODD: if (!w_hold) begin
          r_odd      <= bus.rd_data;
          r_pair_vld <= 1'b1;
          if (r_n == LAST_N) begin
            r_state <= DRAIN;
          end else begin
            r_n     <= r_n + 1'b1;
            r_state <= FETCH_EVEN;
          end
        end
        DRAIN: if (w_empty) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.even_o     = r_even;
  assign bus.odd_o      = r_odd;
  assign bus.pair_valid = r_pair_vld;
  assign busy           = r_busy;
  assign done           = r_done;

  dwt_valid_pipe #(
    .IMG_W  (IMG_W),
    .LAT    (LAT),
    .ADDR_W (ADDR_W)
  ) u_valid_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       ((r_state == IDLE) && start),
    .i_vld       (r_pair_vld),
    .o_wr_en     (bus.wr_en),
    .o_wr_addr_l (bus.wr_addr_l),
    .o_wr_addr_h (bus.wr_addr_h),
    .o_empty     (w_empty)
  );

endmodule

// File: tb/tb_dwt_row_sequencer.sv
// Bench for dwt_row_sequencer: 8x8 frame, LAT=3, ROM model with random pixels.
// Checkpoint table for frame timing, scoreboard queues for pairs and coefficient writes.
module tb_dwt_row_sequencer;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DW = 8;
  localparam int LT = 3;
  localparam int AW = 6;
  localparam int NP = W * H / 2;
`ifdef DWT_SEQ_HOLD_EN
  localparam int HD = 5;
`else
  localparam int HD = 0;
`endif

  typedef struct { logic [DW-1:0] e; logic [DW-1:0] o; int c; } pair_t;
  typedef struct { logic [AW-1:0] l; logic [AW-1:0] h; int c; } wr_t;
  typedef struct { int c; bit rd_en; int rd_addr; bit pv; bit wr_en; int wl; int wh; bit busy; bit done; } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic busy, done;
  logic [DW-1:0] rom [W*H];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_abs = 0;
  int wr_seen = 0;
  bit mon_en = 1'b0;
  bit prev_pv = 1'b0;
  pair_t pq[$];
  wr_t   wq[$];
  vec_t  tbl[15];

  dwt_row_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  assign bus.rd_data = rom[bus.rd_addr];

  dwt_row_sequencer #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .LAT(LT), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected pairs and writes for a frame whose start is driven in absolute cycle b.
  task automatic push_frame(input int b, input int hold_n, input int dly);
    pair_t p;
    wr_t   w;
    for (int n = 0; n < NP; n++) begin
      p.e = rom[2*n];
      p.o = rom[2*n+1];
      p.c = b + 3 + 2*n + ((n >= hold_n) ? dly : 0);
      pq.push_back(p);
      w.l = AW'((n / (W/2)) * W + (n % (W/2)));
      w.h = AW'((n / (W/2)) * W + W/2 + (n % (W/2)));
      w.c = p.c + LT;
      wq.push_back(w);
    end
  endtask

  task automatic check_tbl(input int c);
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].c == c) begin
        chk("tbl_rd_en", bus.rd_en, tbl[i].rd_en);
        if (tbl[i].rd_en) chk("tbl_rd_addr", bus.rd_addr, tbl[i].rd_addr);
        chk("tbl_pair_valid", bus.pair_valid, tbl[i].pv);
        chk("tbl_wr_en", bus.wr_en, tbl[i].wr_en);
        if (tbl[i].wr_en) begin
          chk("tbl_wr_addr_l", bus.wr_addr_l, tbl[i].wl);
          chk("tbl_wr_addr_h", bus.wr_addr_h, tbl[i].wh);
        end
        chk("tbl_busy", busy, tbl[i].busy);
        chk("tbl_done", done, tbl[i].done);
      end
    end
  endtask

  // Scoreboard: every pair_valid / wr_en pops the oldest expectation and checks data and cycle.
  always @(negedge clk) begin
    pair_t pe;
    wr_t   we;
    if (mon_en) begin
      if (bus.pair_valid) begin
        chk("pv_back_to_back", prev_pv, 1'b0);
        chk("pv_expected", pq.size() != 0, 1'b1);
        if (pq.size() != 0) begin
          pe = pq.pop_front();
          chk("pv_even", bus.even_o, pe.e);
          chk("pv_odd", bus.odd_o, pe.o);
          chk("pv_cycle", cyc_abs, pe.c);
        end
      end
      prev_pv = bus.pair_valid;
      if (bus.wr_en) begin
        wr_seen++;
        chk("wr_expected", wq.size() != 0, 1'b1);
        if (wq.size() != 0) begin
          we = wq.pop_front();
          chk("wr_addr_l", bus.wr_addr_l, we.l);
          chk("wr_addr_h", bus.wr_addr_h, we.h);
          chk("wr_cycle", cyc_abs, we.c);
        end
      end
    end
  end

  initial begin
    int b1, b2, b3;
    //            c   rd  addr pv wr  wl  wh busy done
    tbl[0]  = '{  0, 0,  0, 0, 0,  0,  0, 0, 0};
    tbl[1]  = '{  1, 1,  0, 0, 0,  0,  0, 1, 0};
    tbl[2]  = '{  2, 1,  1, 0, 0,  0,  0, 1, 0};
    tbl[3]  = '{  3, 1,  2, 1, 0,  0,  0, 1, 0};
    tbl[4]  = '{  6, 1,  5, 0, 1,  0,  4, 1, 0};
    tbl[5]  = '{ 12, 1, 11, 0, 1,  3,  7, 1, 0};
    tbl[6]  = '{ 14, 1, 13, 0, 1,  8, 12, 1, 0};
    tbl[7]  = '{ 15, 1, 14, 1, 0,  0,  0, 1, 0};
    tbl[8]  = '{ 16, 1, 15, 0, 1,  9, 13, 1, 0};
    tbl[9]  = '{ 21, 1, 20, 1, 0,  0,  0, 1, 0};
    tbl[10] = '{ 64, 1, 63, 0, 1, 57, 61, 1, 0};
    tbl[11] = '{ 65, 0,  0, 1, 0,  0,  0, 1, 0};
    tbl[12] = '{ 68, 0,  0, 0, 1, 59, 63, 1, 0};
    tbl[13] = '{ 69, 0,  0, 0, 0,  0,  0, 1, 1};
    tbl[14] = '{ 70, 0,  0, 0, 0,  0,  0, 0, 0};
    for (int i = 0; i < W*H; i++) rom[i] = DW'($urandom_range(255, 0));

    // Reset values.
    #3;
    chk("reset_outputs", {bus.rd_addr, bus.rd_en, bus.even_o, bus.odd_o, bus.pair_valid,
                          bus.wr_addr_l, bus.wr_addr_h, bus.wr_en, busy, done}, 64'd0);
    #19 rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 1'b0);
    mon_en = 1'b1;

    // Frame 1: start in cycle 0, stray start in cycle 20, start held high from cycle 60.
    step();
    start = 1'b1;
    b1 = cyc_abs;
    wr_seen = 0;
    push_frame(b1, NP, 0);
    @(negedge clk);
    check_tbl(0);
    for (int c = 1; c <= 72; c++) begin
      step();
      if (c == 1)  start = 1'b0;
      if (c == 20) start = 1'b1;
      if (c == 21) start = 1'b0;
      if (c == 60) start = 1'b1;
      @(negedge clk);
      if (c <= 64) begin
        chk("f1_rd_en", bus.rd_en, 1'b1);
        chk("f1_rd_addr", bus.rd_addr, c - 1);
      end
      check_tbl(c);
      if (c == 70) begin
        chk("f1_wr_count", wr_seen, NP);
        chk("f1_wq_empty", wq.size(), 0);
        wr_seen = 0;
        push_frame(b1 + 70, NP, 0);
      end
      if (c == 71 || c == 72) begin
        chk("f2_restart_rd_en", bus.rd_en, 1'b1);
        chk("f2_restart_rd_addr", bus.rd_addr, c - 71);
      end
    end

    // Frame 2 (back-to-back from held start), aborted by reset in its cycle 30.
    b2 = b1 + 70;
    for (int c = 3; c <= 29; c++) begin
      step();
      if (c == 5) start = 1'b0;
      @(negedge clk);
      chk("f2_rd_addr", bus.rd_addr, c - 1);
    end
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", {bus.rd_addr, bus.rd_en, bus.even_o, bus.odd_o, bus.pair_valid,
                                   bus.wr_addr_l, bus.wr_addr_h, bus.wr_en, busy, done}, 64'd0);
    pq.delete();
    wq.delete();
    step();
    rst_n = 1'b1;
    wr_seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      @(negedge clk);
      chk("post_reset_wr_en", bus.wr_en, 1'b0);
      chk("post_reset_busy", busy, 1'b0);
    end
    chk("post_reset_wr_count", wr_seen, 0);
    if (b2 < 0) $display("frame 2 base %0d", b2);

    // Frame 3: hold asserted in cycles 10..14 (stalls only when the feature is built in).
    step();
    start = 1'b1;
    b3 = cyc_abs;
    wr_seen = 0;
    push_frame(b3, 4, HD);
    for (int c = 1; c <= 76; c++) begin
      step();
      if (c == 1) start = 1'b0;
      hold = (c >= 10 && c <= 14);
      @(negedge clk);
      if (c >= 10 && c <= 14) begin
        chk("hold_rd_en", bus.rd_en, (HD == 0));
        chk("hold_rd_addr", bus.rd_addr, (HD == 0) ? c - 1 : 9);
      end
      if (c == 12) chk("hold_inflight_wr_en", bus.wr_en, 1'b1);
      if (c == 68 + HD) begin
        chk("f3_last_wr_en", bus.wr_en, 1'b1);
        chk("f3_last_wr_addr_h", bus.wr_addr_h, 63);
        chk("f3_done_early", done, 1'b0);
      end
      if (c == 69 + HD) chk("f3_done", done, 1'b1);
      if (c == 70 + HD) chk("f3_busy_after", busy, 1'b0);
    end
    hold = 1'b0;
    chk("f3_wr_count", wr_seen, NP);
    chk("f3_pq_empty", pq.size(), 0);
    chk("f3_wq_empty", wq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
